// File: rtl/exe_mdu_ctrl.sv
// Iterative RV64M multiply/divide sequencer: N+1 cycles per op (N=32 word, XLEN full), 1 cycle for special cases.
// Holds upstream via busy/in_ready; the result is held until out_ready. `MDU_ZERO_BYPASS_EN adds zero-multiply early exit.
module exe_mdu_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic            is_word,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_data,
  output logic            busy
);

  localparam int HW = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  function automatic logic [XLEN-1:0] f_sext(input logic [HW-1:0] v);
    return {{(XLEN-HW){v[HW-1]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] f_zext(input logic [HW-1:0] v);
    return {{(XLEN-HW){1'b0}}, v};
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic [XLEN-1:0]  r_opa;
  logic [2:0]       r_op;
  logic             r_word;
  logic             r_neg;
  logic             r_neg_rem;
  logic             r_spec;
  logic             r_out_valid;
  logic [XLEN-1:0]  r_rd_data;

  // Operand preparation for the accept cycle.
  logic            w_s1, w_s2, w_n1, w_n2;
  logic [XLEN-1:0] w_x1, w_x2, w_a1, w_a2, w_min;
  logic            w_div0, w_ovf, w_zero_mul, w_spec;
  logic [XLEN-1:0] w_spec_raw, w_spec_res;

  always_comb begin
    w_s1 = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    w_s2 = w_s1 && (op != OP_MULHSU);
    if (is_word) begin
      w_x1 = w_s1 ? f_sext(op1[HW-1:0]) : f_zext(op1[HW-1:0]);
      w_x2 = w_s2 ? f_sext(op2[HW-1:0]) : f_zext(op2[HW-1:0]);
      w_min = {{(XLEN-HW+1){1'b1}}, {(HW-1){1'b0}}};
    end else begin
      w_x1 = op1;
      w_x2 = op2;
      w_min = {1'b1, {(XLEN-1){1'b0}}};
    end
    w_n1 = w_s1 && w_x1[XLEN-1];
    w_n2 = w_s2 && w_x2[XLEN-1];
    w_a1 = w_n1 ? -w_x1 : w_x1;
    w_a2 = w_n2 ? -w_x2 : w_x2;
    w_div0 = op[2] && (w_x2 == '0);
    w_ovf  = op[2] && w_s1 && (w_x1 == w_min) && (&w_x2);
`ifdef MDU_ZERO_BYPASS_EN
    w_zero_mul = !op[2] && ((w_x1 == '0) || (w_x2 == '0));
`else
    w_zero_mul = 1'b0;
`endif
    w_spec = w_div0 || w_ovf || w_zero_mul;
    // op[1] separates REM/REMU from DIV/DIVU; the overflow quotient is the dividend itself.
    if (w_div0)
      w_spec_raw = op[1] ? w_x1 : '1;
    else if (w_ovf)
      w_spec_raw = op[1] ? '0 : w_x1;
    else
      w_spec_raw = '0;
    w_spec_res = is_word ? f_sext(w_spec_raw[HW-1:0]) : w_spec_raw;
  end

  // One iteration step of each datapath.
  logic [XLEN:0]    w_add, w_rsh, w_trial;
  logic [CNT_W-1:0] w_last;

  always_comb begin
    w_add   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : {(XLEN+1){1'b0}});
    w_rsh   = {r_hi, r_lo[XLEN-1]};
    w_trial = w_rsh - {1'b0, r_opa};
    w_last  = r_word ? CNT_W'(HW-1) : CNT_W'(XLEN-1);
  end

  // Sign correction and result selection once the iterations are finished.
  logic [2*XLEN-1:0] w_p, w_ps;
  logic [XLEN-1:0]   w_q, w_r, w_sel, w_res;

  always_comb begin
    w_p   = r_word ? ({r_hi, r_lo} >> HW) : {r_hi, r_lo};
    w_ps  = r_neg ? -w_p : w_p;
    w_q   = r_neg ? -r_lo : r_lo;
    w_r   = r_neg_rem ? -r_hi : r_hi;
    w_sel = '0;
    case (r_op)
      OP_MUL:                        w_sel = w_ps[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_sel = w_ps[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               w_sel = w_q;
      OP_REM, OP_REMU:               w_sel = w_r;
      default:                       w_sel = '0;
    endcase
    w_res = r_word ? f_sext(w_sel[HW-1:0]) : w_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_opa       <= '0;
      r_op        <= '0;
      r_word      <= 1'b0;
      r_neg       <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_spec      <= 1'b0;
      r_out_valid <= 1'b0;
      r_rd_data   <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_cnt     <= '0;
            r_op      <= op;
            r_word    <= is_word;
            r_neg     <= w_n1 ^ w_n2;
            r_neg_rem <= w_n1;
            r_spec    <= w_spec;
            r_hi      <= '0;
            if (w_spec) begin
              r_state   <= S_DONE;
              r_rd_data <= w_spec_res;
            end else if (op[2]) begin
              // Word dividends are left-aligned so 32 steps consume all their bits.
              r_state <= S_DIV;
              r_lo    <= is_word ? (w_a1 << HW) : w_a1;
              r_opa   <= w_a2;
            end else begin
              r_state <= S_MUL;
              r_lo    <= w_a2;
              r_opa   <= w_a1;
            end
          end
        end
        S_MUL: begin
          r_hi  <= w_add[XLEN:1];
          r_lo  <= {w_add[0], r_lo[XLEN-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_last) r_state <= S_DONE;
        end
        S_DIV: begin
          r_hi  <= w_trial[XLEN] ? w_rsh[XLEN-1:0] : w_trial[XLEN-1:0];
          r_lo  <= {r_lo[XLEN-2:0], ~w_trial[XLEN]};
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == w_last) r_state <= S_DONE;
        end
        S_DONE: begin
          // First DONE cycle finalises the result; the handshake can only follow.
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            if (!r_spec) r_rd_data <= w_res;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_exe_mdu_ctrl.sv
// Scoreboard bench for exe_mdu_ctrl: directed M-extension vectors, latency, flush, hold and reset behaviour.
module tb_exe_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, is_word, flush, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [63:0] op1, op2, rd_data;

  exe_mdu_ctrl #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .is_word(is_word), .op1(op1), .op2(op2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .rd_data(rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int          due;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Monitor: first out_valid cycle checks latency, every valid cycle checks data, handshake pops.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got rd_data %h with no request outstanding", rd_data);
        end else begin
          if (!mon_seen) begin
            chk($sformatf("latency#%0d", sb[0].id), 64'(cyc), 64'(sb[0].due));
            mon_seen = 1'b1;
          end
          chk($sformatf("rd_data#%0d", sb[0].id), rd_data, sb[0].d);
          if (out_ready === 1'b1) begin
            void'(sb.pop_front());
            mon_seen = 1'b0;
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge T.
  task automatic issue(input int id, input logic [2:0] o, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] e, input int lat, input bit push);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue#%0d: in_ready still %b after %0d cycles, expected 1", id, in_ready, guard);
    end else begin
      op = o; is_word = w; op1 = a; op2 = b; in_valid = 1'b1;
      if (push) sb.push_back('{d: e, due: cyc + 1 + lat, id: id});
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int guard;
    guard = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  localparam int ZLAT =
`ifdef MDU_ZERO_BYPASS_EN
    1;
`else
    33;
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; is_word = 1'b0; op1 = '0; op2 = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("in_ready_during_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_rd_data", rd_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    issue(1, 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65, 1'b1);
    begin : busy_blk
      int bad;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
        if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
        @(posedge clk); #1;
      end
      chk("mul_busy_cycles_bad", 64'(bad), 64'd0);
    end

    issue(2,  3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, 1'b1);
    issue(3,  3'd1, 1'b0, '1, '1, 64'd0, 65, 1'b1);
    issue(4,  3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
    issue(5,  3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 1'b1);
    issue(6,  3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 1'b1);
    issue(7,  3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65, 1'b1);
    issue(8,  3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65, 1'b1);
    issue(9,  3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);
    issue(10, 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1'b1);
    issue(11, 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1, 1'b1);
    issue(12, 3'd0, 1'b1, 64'h0000_0001_0000_0003, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFD, 33, 1'b1);
    issue(13, 3'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 33, 1'b1);
    issue(14, 3'd6, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 1'b1);
    issue(15, 3'd7, 1'b1, 64'h0000_0001_8000_0000, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 1, 1'b1);
    issue(16, 3'd0, 1'b1, 64'h0000_0005_0000_0000, 64'd9, 64'd0, ZLAT, 1'b1);

    // Flush mid-divide with a competing request.
    issue(20, 3'd4, 1'b0, 64'd1000, 64'd7, 64'd0, 0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; op = 3'd5; op1 = 64'd9; op2 = 64'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    repeat (70) @(posedge clk);
    #1;
    chk("flush_still_idle", 64'(busy), 64'd0);

    // Result held while out_ready is low.
    wait_idle("idle_before_hold");
    out_ready = 1'b0;
    issue(21, 3'd5, 1'b0, 64'd77, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b1);
    begin : hold_blk
      int held;
      held = 0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (out_valid === 1'b1 && rd_data === 64'hFFFF_FFFF_FFFF_FFFF) held++;
      end
      chk("hold_cycles", 64'(held), 64'd5);
    end
    out_ready = 1'b1;
    wait_idle("idle_after_hold");

    // Flush discards a result waiting in DONE.
    out_ready = 1'b0;
    issue(22, 3'd7, 1'b0, 64'd123, 64'd0, 64'd123, 1, 1'b1);
    @(posedge clk); #1;
    chk("done_out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("done_flush_out_valid", 64'(out_valid), 64'd0);
    chk("done_flush_busy", 64'(busy), 64'd0);
    if (sb.size() != 0) void'(sb.pop_front());
    mon_seen = 1'b0;
    out_ready = 1'b1;

    // Reset in the middle of a multiply.
    issue(23, 3'd0, 1'b0, 64'd5, 64'd6, 64'd0, 0, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_rd_data", rd_data, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    repeat (70) @(posedge clk);
    #1;
    chk("postrst_in_ready", 64'(in_ready), 64'd1);
    chk("postrst_busy", 64'(busy), 64'd0);

    begin : drain_blk
      int guard;
      guard = 0;
      while (sb.size() != 0 && guard < 2000) begin
        @(posedge clk); #1;
        guard++;
      end
      chk("scoreboard_left", 64'(sb.size()), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_mdu_ctrl.md
Name: exe_mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit and its sequencer for the execute stage of the RV64 core.
- Accepts one M-extension operation from the decode/execute boundary and runs an iterative shift-add multiplier or restoring divider.
- Holds the pipeline via `busy` and returns a 64-bit result with a valid/ready handshake. The single-cycle ALU stays separate.

Parameters:
- XLEN, 64, operand/result width; must match the core register width.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request
- op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- is_word  input  1  RV64 *W variant; only valid with op 0, 4, 5, 6, 7
- op1  input  XLEN  rs1 value
- op2  input  XLEN  rs2 value
- flush  input  1  kill in-flight operation (branch/exception)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- rd_data  output  XLEN  result
- busy  output  1  state != IDLE; stalls upstream

Behaviour:
- Reset is synchronous, active-high: rst sampled high on a rising clk edge resets the block.
  - After that edge: state IDLE, out_valid=0, rd_data=0, counter=0, internal accumulators=0, busy=0.
  - in_ready is forced to 0 while rst is high.
  - rst high mid-operation abandons the operation; no out_valid is produced for it.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready (accept edge T), operands are latched and the next state is selected:
    - DONE if a special case applies;
    - MUL for op 0–3;
    - DIV for op 4–7.
- Operand preparation at accept:
  - For is_word, use op1[31:0]/op2[31:0]; sign-extend for signed ops (MUL, DIV, REM), zero-extend for unsigned.
  - Signed ops take absolute values and record the result sign.
  - MULHSU treats op1 as signed and op2 as unsigned.
- Iteration count N = 32 when is_word, else XLEN.
- MUL state: one shift-add step per cycle on a 2*XLEN product register; after N steps go to DONE.
- DIV state: one restoring step per cycle (shift remainder, trial subtract, set quotient bit); after N steps go to DONE.
- Latency, accept edge T to out_valid high:
  - normal op: N+1 cycles (65 for 64-bit, 33 for word);
  - special case: 1 cycle.
- DONE:
  - out_valid=1; rd_data is stable until handshake.
  - On out_valid && out_ready, next state is IDLE and out_valid=0.
  - No new accept in the same cycle as the output handshake; the earliest next accept is the following cycle.
- Result selection:
  - MUL: low XLEN bits.
  - MULH/MULHSU/MULHU: high XLEN bits, after sign correction of the full 2*XLEN product.
  - DIV/DIVU: quotient; REM/REMU: remainder.
  - Quotient sign = sign(op1) XOR sign(op2); remainder sign = sign(op1).
  - is_word: rd_data = sign-extension of result[31:0] for all ops, unsigned ones included.
- Special cases (go straight to DONE):
  - divide by zero: quotient = all ones, remainder = dividend;
  - signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - MIN is 32-bit for word ops, then sign-extended.
- Flush:
  - Takes effect in any state; next state is IDLE and out_valid=0.
  - flush takes priority over accept: in_valid during flush is not accepted.
  - flush takes priority over the output handshake: a result in DONE is discarded.
- busy is combinational: busy = (state != IDLE).

Optional Feature:
- MDU_ZERO_BYPASS_EN
- Defined: a multiply with op1==0 or op2==0 (after word extension) goes straight to DONE with rd_data=0, giving 1-cycle latency.
- Not defined: zero multiplies take the normal N+1 cycles; the result is identical.

Test Plan:
- MUL, op1=7, op2=-3 (0xFFFF_FFFF_FFFF_FFFD), out_ready=1 -> out_valid at T+65, rd_data=0xFFFF_FFFF_FFFF_FFEB; in_ready=0 and busy=1 throughout.
- MULHU, op1=op2=0xFFFF_FFFF_FFFF_FFFF -> rd_data=0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0.
- DIV, op1=-7, op2=2 -> rd_data=-3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands -> -1.
- DIVU, op2=0, op1=5 -> out_valid at T+1, rd_data=all ones. REM, op1=0x8000_0000_0000_0000, op2=-1 -> rd_data=0 at T+1.
- DIVW, op1=0x0000_0000_8000_0000, op2=0xFFFF_FFFF -> rd_data=0xFFFF_FFFF_8000_0000 at T+1. MULW, op1=0x1_0000_0003, op2=0x7FFF_FFFF -> rd_data=0x0000_0000_7FFF_FFFD at T+33.
- Start DIV, assert flush at T+10 with in_valid=1 -> IDLE at T+11, no out_valid, request not accepted. Hold out_ready=0 in DONE for 5 cycles -> rd_data stable, out_valid held. rst at T+20 of a MUL -> all outputs 0 and state IDLE after that edge.
